// File: rtl/bus_button_ctrl.sv
// bus_button_ctrl: bus-mapped peripheral for four direction push-buttons.
// It synchronises and debounces the buttons, latches press events and
// raises an interrupt to the processor.
// Registers (BASE_ADDR+0..+2): stable levels, sticky events (clear on read),
// and the IRQ mask (read/write).
// Optional: define BUTTON_RELEASE_EVT_EN to also latch release events in
// EVT[7:4], with mask[7:4] gating the matching release interrupts.
module bus_button_ctrl #(
  parameter logic [7:0] BASE_ADDR       = 8'hC0,
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         CNT_WIDTH       = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] BUTTONS,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
`ifdef BUTTON_RELEASE_EVT_EN
  localparam logic [7:0] MASK_BITS = 8'hFF;
`else
  localparam logic [7:0] MASK_BITS = 8'h0F;
`endif

  typedef enum logic {IDLE = 1'b0, RAISED = 1'b1} irq_state_t;

  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic [3:0]           r_stable;
  logic [CNT_WIDTH-1:0] r_cnt [4];
  logic [7:0]           r_evt;
  logic [7:0]           r_mask;
  logic [7:0]           r_rdata;
  logic                 r_drive;
  irq_state_t           r_state;
  logic                 r_again;
  logic                 r_raise;

  logic [3:0] w_settle;
  logic [3:0] w_rise;
  logic [7:0] w_new_evt;
  logic [7:0] w_off;
  logic       w_in_win;
  logic       w_rd;
  logic       w_rd_evt;
  logic       w_wr_mask;
  logic       w_new_irq;
  logic [7:0] w_rd_val;

  // A button settles when its synchronised level has differed from the
  // stable level for the full debounce period.
  always_comb begin
    w_settle = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX)) begin
        w_settle[i] = 1'b1;
      end else begin
        w_settle[i] = 1'b0;
      end
    end
  end

  assign w_rise = w_settle & r_sync2;

`ifdef BUTTON_RELEASE_EVT_EN
  logic [3:0] w_fall;
  assign w_fall    = w_settle & ~r_sync2;
  assign w_new_evt = {w_fall, w_rise};
`else
  assign w_new_evt = {4'b0000, w_rise};
`endif

  // Address decode: the window is BASE..BASE+2; subtraction wraps safely.
  assign w_off     = BUS_ADDR - BASE_ADDR;
  assign w_in_win  = (w_off < 8'd3);
  assign w_rd      = w_in_win & ~BUS_WE;
  assign w_rd_evt  = w_rd & (w_off == 8'd1);
  assign w_wr_mask = w_in_win & BUS_WE & (w_off == 8'd2);
  assign w_new_irq = |(w_new_evt & r_mask);

  // Read multiplexer for the three registers in the window.
  always_comb begin
    w_rd_val = 8'h00;
    case (w_off)
      8'd0:    w_rd_val = {4'b0000, r_stable};
      8'd1:    w_rd_val = r_evt;
      8'd2:    w_rd_val = r_mask;
      default: w_rd_val = 8'h00;
    endcase
  end

  // Two-flop synchroniser followed by a per-button stability counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1  <= 4'b0000;
      r_sync2  <= 4'b0000;
      r_stable <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      r_sync1 <= BUTTONS;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= CNT_ZERO;
        end else if (w_settle[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= CNT_ZERO;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Sticky events, IRQ mask and the registered read path. A read of the
  // event register keeps only the events arriving on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_evt   <= 8'h00;
      r_mask  <= 8'h00;
      r_rdata <= 8'h00;
      r_drive <= 1'b0;
    end else begin
      if (w_rd_evt) begin
        r_evt <= w_new_evt;
      end else begin
        r_evt <= r_evt | w_new_evt;
      end
      if (w_wr_mask) begin
        r_mask <= BUS_DATA & MASK_BITS;
      end else begin
        r_mask <= r_mask;
      end
      r_drive <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_val;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Interrupt FSM; 'again' remembers an unmasked event that arrived while
  // the previous request was still outstanding.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_raise <= 1'b0;
      r_again <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_new_irq || r_again) begin
            r_state <= RAISED;
            r_raise <= 1'b1;
            r_again <= 1'b0;
          end else begin
            r_raise <= 1'b0;
          end
        end
        RAISED: begin
          if (BUS_INTERRUPT_ACK) begin
            r_state <= IDLE;
            r_raise <= 1'b0;
            r_again <= r_again | w_new_irq;
          end else begin
            r_raise <= 1'b1;
            if (w_new_irq) begin
              r_again <= 1'b1;
            end else begin
              r_again <= r_again;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_raise <= 1'b0;
          r_again <= 1'b0;
        end
      endcase
    end
  end

  assign BUS_DATA            = r_drive ? r_rdata : 8'hzz;
  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_bus_button_ctrl.sv
// Testbench for bus_button_ctrl (DEBOUNCE_CYCLES=8, CNT_WIDTH=4).
module tb_bus_button_ctrl;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [3:0] buttons;
  logic       irq_raise;
  logic       irq_ack;
  logic       tb_drv;
  logic [7:0] tb_wdata;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  always #5 clk = ~clk;

  bus_button_ctrl #(
    .BASE_ADDR(8'hC0),
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH(4)
  ) u_dut (
    .CLK(clk),
    .RESET(rst),
    .BUS_DATA(bus_data),
    .BUS_ADDR(bus_addr),
    .BUS_WE(bus_we),
    .BUTTONS(buttons),
    .BUS_INTERRUPT_RAISE(irq_raise),
    .BUS_INTERRUPT_ACK(irq_ack)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [3:0] hist [$];
  logic [3:0] m_stable;
  logic [7:0] m_evt, m_mask, m_rdata;
  logic       m_drv, m_raise, m_pend;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] exp_data;
    logic       exp_raise;
  } vec_t;

  vec_t vecs [22];

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < D + 2; j++) hist.push_back(4'b0000);
    m_stable = 4'h0; m_evt = 8'h00; m_mask = 8'h00; m_rdata = 8'h00;
    m_drv = 1'b0; m_raise = 1'b0; m_pend = 1'b0;
  endtask

  // One clock edge of the behavioural model, from the inputs seen at the edge.
  task automatic model_step();
    logic [3:0] nstable, rise;
    logic [7:0] newev, rdv;
    logic       rd, irq;
    int         differ;
    hist.push_front(buttons);
    if (hist.size() > D + 2) void'(hist.pop_back());
    nstable = m_stable;
    for (int i = 0; i < 4; i++) begin
      differ = 0;
      for (int j = 2; j < D + 2; j++) if (hist[j][i] != m_stable[i]) differ++;
      if (differ == D) nstable[i] = ~m_stable[i];
    end
    rise  = nstable & ~m_stable;
`ifdef BUTTON_RELEASE_EVT_EN
    newev = {~nstable & m_stable, rise};
`else
    newev = {4'h0, rise};
`endif
    rd  = (bus_addr >= 8'hC0) && (bus_addr <= 8'hC2) && !bus_we;
    rdv = (bus_addr == 8'hC0) ? {4'h0, m_stable} : (bus_addr == 8'hC1) ? m_evt : m_mask;
    irq = |(newev & m_mask);
    if (rd && bus_addr == 8'hC1) m_evt = newev;
    else m_evt = m_evt | newev;
    if (bus_we && bus_addr == 8'hC2) begin
`ifdef BUTTON_RELEASE_EVT_EN
      m_mask = tb_wdata;
`else
      m_mask = tb_wdata & 8'h0F;
`endif
    end
    if (m_raise) begin
      if (irq_ack) begin
        m_raise = 1'b0;
        m_pend  = m_pend | irq;
      end else if (irq) begin
        m_pend = 1'b1;
      end
    end else if (irq || m_pend) begin
      m_raise = 1'b1;
      m_pend  = 1'b0;
    end
    m_drv = rd;
    if (rd) m_rdata = rdv;
    m_stable = nstable;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_bus(input logic [7:0] a, input logic w, input logic [7:0] d, input logic k);
    bus_addr = a; bus_we = w; tb_drv = w; tb_wdata = d; irq_ack = k;
  endtask

  task automatic idle_bus();
    set_bus(8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_raise(input string name, input logic exp);
    n_total++;
    if (irq_raise === exp) n_pass++;
    else $display("FAIL %s: RAISE=%b expected %b", name, irq_raise, exp);
  endtask

  // An undriven bus reads z in 4-state simulators and 0 in 2-state ones.
  task automatic check_data(input string name, input logic exp_drv, input logic [7:0] exp);
    logic ok;
    n_total++;
    if (exp_drv) ok = (bus_data === exp);
    else ok = (bus_data === 8'hzz) || (bus_data === 8'h00);
    if (ok) n_pass++;
    else if (exp_drv) $display("FAIL %s: BUS_DATA=%h expected %h", name, bus_data, exp);
    else $display("FAIL %s: BUS_DATA=%h expected undriven", name, bus_data);
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    set_bus(a, 1'b0, 8'h00, 1'b0);
    tick();
    check_data(name, 1'b1, exp);
    idle_bus();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    set_bus(a, 1'b1, d, 1'b0);
    tick();
    idle_bus();
  endtask

  task automatic apply_vec(input int k, input vec_t v);
    buttons = v.btn;
    idle_bus();
    repeat (v.hold) tick();
    set_bus(v.addr, v.we, v.wdata, v.ack);
    tick();
    check_raise($sformatf("vec%0d_raise", k), v.exp_raise);
    if (!v.we) check_data($sformatf("vec%0d_data", k),
                          (v.addr >= 8'hC0) && (v.addr <= 8'hC2), v.exp_data);
    idle_bus();
  endtask

  initial begin
    logic       seen;
    logic [7:0] a;
    logic       w;
    int         r;

    //            btn     hold addr   we    wdata  ack   exp    raise
    vecs[0]  = '{4'b0001, 9,  8'hC0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{4'b0001, 0,  8'hC0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[2]  = '{4'b0001, 3,  8'hC1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[3]  = '{4'b0001, 0,  8'hC1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{4'b0000, 12, 8'hC0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{4'b0000, 1,  8'hC2, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{4'b0000, 0,  8'hC2, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0};
    vecs[7]  = '{4'b0010, 8,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{4'b0010, 0,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{4'b0010, 5,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{4'b0010, 0,  8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[11] = '{4'b0010, 3,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{4'b0010, 0,  8'hC1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0};
    vecs[13] = '{4'b0011, 12, 8'hC1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[14] = '{4'b0010, 12, 8'hC2, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{4'b0011, 9,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[16] = '{4'b1011, 12, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[17] = '{4'b1011, 0,  8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[18] = '{4'b1011, 0,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[19] = '{4'b1011, 0,  8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[20] = '{4'b1011, 2,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[21] = '{4'b1011, 0,  8'hC1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0};

    // Reset state
    rst = 1'b1;
    buttons = 4'b0000;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_raise("reset_raise", 1'b0);
    check_data("reset_bus", 1'b0, 8'h00);
    rst = 1'b0;
    model_reset();
    tick();

    // Table-driven vectors
    for (int k = 0; k < 22; k++) apply_vec(k, vecs[k]);

    // Bouncing button 2 never settles
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) buttons[2] = ~buttons[2];
      tick();
      if (irq_raise !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if (seen === 1'b0) n_pass++;
    else $display("FAIL glitch_raise: RAISE seen=%b expected 0", seen);
    repeat (4) tick();
    read_chk("glitch_stable", 8'hC0, 8'h0B);
    read_chk("glitch_evt", 8'hC1, 8'h00);

    // Read-clear on the same edge as a new press
    buttons = 4'b0000;
    repeat (12) tick();
    write_reg(8'hC2, 8'h00);
    buttons = 4'b0001;
    repeat (12) tick();
    buttons = 4'b0011;
    repeat (9) tick();
    read_chk("rdclr_old", 8'hC1, 8'h01);
    tick();
    read_chk("rdclr_new", 8'hC1, 8'h02);

    // Reset while raised and mid-debounce
    buttons = 4'b0000;
    repeat (12) tick();
    write_reg(8'hC2, 8'h0F);
    buttons = 4'b0100;
    repeat (10) tick();
    check_raise("pre_rst_raise", 1'b1);
    buttons = 4'b0000;
    repeat (3) tick();
    read_chk("pre_rst_mask", 8'hC2, 8'h0F);
    set_bus(8'hC2, 1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    idle_bus();
    #1;
    check_raise("rst_async_raise", 1'b0);
    check_data("rst_async_bus", 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    read_chk("post_rst_stable", 8'hC0, 8'h00);
    read_chk("post_rst_evt", 8'hC1, 8'h00);
    read_chk("post_rst_mask", 8'hC2, 8'h00);
    check_raise("post_rst_raise", 1'b0);

    // Randomised traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) buttons[b] = ~buttons[b];
      r = $urandom_range(0, 5);
      case (r)
        0: a = 8'hC0;
        1: a = 8'hC1;
        2: a = 8'hC2;
        3: a = 8'hC3;
        4: a = 8'hBF;
        default: a = 8'($urandom);
      endcase
      w = ($urandom_range(0, 3) == 0) && !m_drv;
      set_bus(a, w, 8'($urandom), $urandom_range(0, 7) == 0);
      tick();
      check_raise("rnd_raise", m_raise);
      if (!w) check_data("rnd_bus", m_drv, m_rdata);
    end
    idle_bus();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
